// File: rtl/as_pack.sv
// Shared types and constants for the GPIO bus controller.
package as_pack;

  // Default external GPIO bus width and address width.
  localparam int nr_gpios        = 8;
  localparam int gpio_addr_width = 4;

  // Reads of this address return the block ID and never reach the pads.
  // Stored as all-ones and truncated to whatever address width is in use.
  localparam logic [31:0] gpio_id_addr = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } gpio_state_e;

  // Requester index: bit 0 of the request vector is the core, bit 1 is debug/JTAG.
  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_DBG  = 1'b1
  } req_sel_e;

endpackage

// File: rtl/as_gpio_ctrl_if.sv
// Requester-side bus of the GPIO controller: two requesters sharing one port.
interface as_gpio_ctrl_if
  import as_pack::*;
#(
  parameter int NR_GPIOS = nr_gpios,
  parameter int ADDR_W   = gpio_addr_width
);

  logic [1:0]               req_i;
  logic [1:0]               we_i;
  logic [1:0][ADDR_W-1:0]   addr_i;
  logic [1:0][NR_GPIOS-1:0] wdata_i;
  logic [1:0]               ack_o;
  logic [NR_GPIOS-1:0]      rdata_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  ack_o, rdata_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output ack_o, rdata_o
  );

endinterface

// File: rtl/as_rr_arb2.sv
// Two-way round-robin arbiter. A tie goes to the requester named by the
// pointer; every accepted grant hands the pointer to the other requester.
module as_rr_arb2
  import as_pack::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       gnt_vld_o,
  output req_sel_e   gnt_o
);

  req_sel_e rr_ptr_q;

  // Grant selection: a lone requester wins outright, a tie follows the pointer.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_o     = rr_ptr_q;
    if (req_i == 2'b01) begin
      gnt_o = REQ_CORE;
    end else if (req_i == 2'b10) begin
      gnt_o = REQ_DBG;
    end
  end

  // Pointer update: after reset the core wins ties; afterwards the one not granted last.
  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= REQ_CORE;
    end else if (accept_i && gnt_vld_o) begin
      rr_ptr_q <= (gnt_o == REQ_CORE) ? REQ_DBG : REQ_CORE;
    end
  end

endmodule

// File: rtl/as_gpio_ctrl.sv
// GPIO bus controller: arbitrates two requesters onto a strobed external
// GPIO bus, with an ID register that answers reads without a bus cycle.
module as_gpio_ctrl
  import as_pack::*;
#(
  parameter int          NR_GPIOS   = nr_gpios,
  parameter int          ADDR_W     = gpio_addr_width,
  parameter int          SETTLE_CYC = 2,
  parameter logic [7:0]  GPIO_ID    = 8'h81
) (
  input  logic                clk_i,
  input  logic                rst_i,
  as_gpio_ctrl_if.slave       bus,
  output logic [NR_GPIOS-1:0] gpio_o,
  output logic                gpio_oe_o,
  input  logic [NR_GPIOS-1:0] gpio_i,
  output logic [ADDR_W-1:0]   gpioAddr_o,
  output logic                cs_o
);

  localparam logic [ADDR_W-1:0] ID_ADDR = gpio_id_addr[ADDR_W-1:0];
  // gpio_i is captured SETTLE_CYC cycles after the strobe: SETTLE covers all
  // but the last of those cycles and SAMPLE is the last one.
  localparam int SETTLE_LAST = (SETTLE_CYC > 1) ? SETTLE_CYC - 2 : 0;

  gpio_state_e         state_q, state_d;
  req_sel_e            gnt;
  logic                gnt_vld;
  logic                accept;
  logic                id_rd;
  req_sel_e            gnt_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [NR_GPIOS-1:0] wdata_q;
  logic [NR_GPIOS-1:0] rdata_q;
  logic [3:0]          settle_cnt;
  logic [1:0]          ack_d;

  assign accept = (state_q == ST_IDLE) && gnt_vld;
  assign id_rd  = !bus.we_i[gnt] && (bus.addr_i[gnt] == ID_ADDR);

  as_rr_arb2 u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.req_i),
    .accept_i  (accept),
    .gnt_vld_o (gnt_vld),
    .gnt_o     (gnt)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one IDLE cycle always separates transactions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_vld) state_d = id_rd ? ST_DONE : ST_SETUP;
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = (SETTLE_CYC > 1) ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_SETTLE: if (settle_cnt == 4'(SETTLE_LAST)) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Pad and handshake outputs decoded from the state; oe only moves at
  // SETUP entry and DONE entry, never in the strobe cycle.
  always_comb begin
    cs_o       = 1'b0;
    gpio_oe_o  = 1'b0;
    gpio_o     = '0;
    gpioAddr_o = '0;
    ack_d      = 2'b00;
    case (state_q)
      ST_SETUP, ST_STROBE: begin
        gpioAddr_o = addr_q;
        gpio_oe_o  = we_q;
        gpio_o     = we_q ? wdata_q : '0;
        cs_o       = (state_q == ST_STROBE);
      end
      ST_SETTLE, ST_SAMPLE: gpioAddr_o = addr_q;
      ST_DONE:              ack_d[gnt_q] = 1'b1;
      default:              ;
    endcase
  end

  // Operand latch at grant, read-data capture, and settle counter.
  // NOTE: the operand and read-data registers are reset too, so the pads and rdata start at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q      <= REQ_CORE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      settle_cnt <= '0;
    end else begin
      if (accept) begin
        gnt_q   <= gnt;
        we_q    <= bus.we_i[gnt];
        addr_q  <= bus.addr_i[gnt];
        wdata_q <= bus.wdata_i[gnt];
        if (id_rd) rdata_q <= NR_GPIOS'(GPIO_ID);
      end
      if (state_q == ST_SAMPLE) rdata_q <= gpio_i;
      settle_cnt <= (state_q == ST_SETTLE) ? settle_cnt + 4'd1 : 4'd0;
    end
  end

  assign bus.ack_o   = ack_d;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_as_gpio_ctrl.sv
// Self-checking bench for as_gpio_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_as_gpio_ctrl;
  import as_pack::*;

  localparam int S = 2;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_o;
  logic       gpio_oe_o;
  logic [7:0] gpio_in;
  logic [3:0] gpio_addr;
  logic       cs_o;

  as_gpio_ctrl_if #(.NR_GPIOS(8), .ADDR_W(4)) bus ();

  as_gpio_ctrl #(.NR_GPIOS(8), .ADDR_W(4), .SETTLE_CYC(S), .GPIO_ID(8'h81)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .gpio_o     (gpio_o),
    .gpio_oe_o  (gpio_oe_o),
    .gpio_i     (gpio_in),
    .gpioAddr_o (gpio_addr),
    .cs_o       (cs_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Transaction-level model. m_cyc is the position of the current cycle in
  // the running transaction (1 = the IDLE cycle it was accepted in, m_len =
  // the ack cycle), or 0 when no transaction is running.
  int         m_cyc = 0, m_len = 0, m_who = 0, m_prio = 0;
  bit         m_we, m_ext, m_valid = 0;
  logic [3:0] m_addr;
  logic [7:0] m_wdata;
  logic [7:0] m_rdata;

  task automatic model_step();
    if (rst) begin
      m_cyc = 0; m_rdata = 8'h00; m_prio = 0; m_valid = 1;
    end else if (m_valid) begin
      if (m_cyc == 0) begin
        if (bus.req_i != 2'b00) begin
          if (bus.req_i == 2'b11) m_who = m_prio;
          else                    m_who = bus.req_i[1] ? 1 : 0;
          m_prio  = 1 - m_who;
          m_we    = bus.we_i[m_who];
          m_addr  = bus.addr_i[m_who];
          m_wdata = bus.wdata_i[m_who];
          m_ext   = m_we || (m_addr != 4'hF);
          m_len   = m_we ? 4 : (m_ext ? 4 + S : 2);
          if (!m_ext) m_rdata = 8'h81;
          m_cyc = 2;
        end
      end else begin
        if (!m_we && m_ext && m_cyc == m_len - 1) m_rdata = gpio_in;
        m_cyc = (m_cyc == m_len) ? 0 : m_cyc + 1;
      end
    end
  endtask

  function automatic logic [1:0] exp_ack_f();
    return (m_cyc != 0 && m_cyc == m_len) ? 2'(1 << m_who) : 2'b00;
  endfunction

  // Compare process: advance the model on each edge, check outputs 1 ns later.
  always @(posedge clk) begin
    model_step();
    #1;
    if (m_valid) begin
      check("cs", 32'(cs_o), 32'(m_ext && m_cyc == 3));
      check("oe", 32'(gpio_oe_o), 32'(m_we && (m_cyc == 2 || m_cyc == 3)));
      check("ack", 32'(bus.ack_o), 32'(exp_ack_f()));
      check("rdata", 32'(bus.rdata_o), 32'(m_rdata));
      if (m_we && (m_cyc == 2 || m_cyc == 3)) check("gpio_o", 32'(gpio_o), 32'(m_wdata));
      if (m_ext && (m_cyc == 2 || m_cyc == 3)) check("gpio_addr", 32'(gpio_addr), 32'(m_addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      if (m_cyc == 0 && bus.req_i == 2'b00) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  logic [1:0] order[$];
  int         idx[2];
  bit [1:0]   active;
  int         cs_cnt;
  bit         done;

  initial begin
    rst = 1'b1;
    bus.req_i = 2'b00; bus.we_i = 2'b00; bus.addr_i = '0; bus.wdata_i = '0;
    gpio_in = 8'h00;
    tick(); tick();
    check("rst_cs", 32'(cs_o), 32'd0);
    check("rst_oe", 32'(gpio_oe_o), 32'd0);
    check("rst_gpio", 32'(gpio_o), 32'd0);
    check("rst_addr", 32'(gpio_addr), 32'd0);
    check("rst_ack", 32'(bus.ack_o), 32'd0);
    check("rst_rdata", 32'(bus.rdata_o), 32'd0);
    rst = 1'b0;
    tick();

    // Both requesters hammer four writes each: grants must alternate core first.
    bus.req_i = 2'b11; bus.we_i = 2'b11;
    bus.addr_i[0] = 4'd1; bus.addr_i[1] = 4'd2;
    bus.wdata_i[0] = 8'h10; bus.wdata_i[1] = 8'h20;
    idx[0] = 0; idx[1] = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (bus.ack_o != 2'b00) order.push_back(bus.ack_o);
      for (int r = 0; r < 2; r++) begin
        if (exp_ack_f()[r]) begin
          idx[r]++;
          if (idx[r] == 4) bus.req_i[r] = 1'b0;
          else bus.wdata_i[r] = 8'((r == 0 ? 8'h10 : 8'h20) + idx[r]);
        end
      end
      done = (idx[0] == 4 && idx[1] == 4);
    end
    check("rr_done", 32'(done), 32'd1);
    check("rr_count", 32'(order.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("rr_order", 32'((i < order.size()) ? order[i] : 2'bxx), 32'((i % 2 == 0) ? 2'b01 : 2'b10));

    // Core write addr 3, data 5A.
    wait_idle();
    bus.req_i = 2'b01; bus.we_i[0] = 1'b1; bus.addr_i[0] = 4'd3; bus.wdata_i[0] = 8'h5A;
    tick();
    check("w_c2_oe", 32'(gpio_oe_o), 32'd1);
    check("w_c2_addr", 32'(gpio_addr), 32'd3);
    check("w_c2_data", 32'(gpio_o), 32'h5A);
    check("w_c2_cs", 32'(cs_o), 32'd0);
    tick();
    check("w_c3_cs", 32'(cs_o), 32'd1);
    check("w_c3_oe", 32'(gpio_oe_o), 32'd1);
    check("w_c3_ack", 32'(bus.ack_o), 32'd0);
    tick();
    check("w_c4_ack", 32'(bus.ack_o), 32'b01);
    check("w_c4_oe", 32'(gpio_oe_o), 32'd0);
    check("w_c4_cs", 32'(cs_o), 32'd0);
    bus.req_i = 2'b00;

    // Debug read addr 2 with pads at C3.
    wait_idle();
    gpio_in = 8'hC3;
    bus.req_i = 2'b10; bus.we_i[1] = 1'b0; bus.addr_i[1] = 4'd2;
    cs_cnt = 0;
    for (int c = 2; c <= 6; c++) begin
      tick();
      cs_cnt += int'(cs_o);
      check("r_oe", 32'(gpio_oe_o), 32'd0);
      if (c < 6) check("r_early_ack", 32'(bus.ack_o), 32'd0);
    end
    check("r_c6_ack", 32'(bus.ack_o), 32'b10);
    check("r_c6_rdata", 32'(bus.rdata_o), 32'hC3);
    check("r_cs_count", 32'(cs_cnt), 32'd1);
    bus.req_i = 2'b00;

    // Core ID read.
    wait_idle();
    bus.req_i = 2'b01; bus.we_i[0] = 1'b0; bus.addr_i[0] = 4'hF;
    tick();
    check("id_ack", 32'(bus.ack_o), 32'b01);
    check("id_rdata", 32'(bus.rdata_o), 32'h81);
    check("id_cs", 32'(cs_o), 32'd0);
    bus.req_i = 2'b00;

    // Reset in the middle of a debug read, then a clean core write.
    wait_idle();
    gpio_in = 8'h5E;
    bus.req_i = 2'b10; bus.we_i[1] = 1'b0; bus.addr_i[1] = 4'd2;
    tick(); tick(); tick();
    rst = 1'b1; bus.req_i = 2'b00;
    tick();
    check("ra_oe", 32'(gpio_oe_o), 32'd0);
    check("ra_ack", 32'(bus.ack_o), 32'd0);
    check("ra_cs", 32'(cs_o), 32'd0);
    check("ra_rdata", 32'(bus.rdata_o), 32'd0);
    rst = 1'b0;
    bus.req_i = 2'b01; bus.we_i[0] = 1'b1; bus.addr_i[0] = 4'd5; bus.wdata_i[0] = 8'h3C;
    tick();
    check("ra_w_data", 32'(gpio_o), 32'h3C);
    tick(); tick();
    check("ra_w_ack", 32'(bus.ack_o), 32'b01);
    bus.req_i = 2'b00;

    // Randomized traffic from both requesters, with occasional resets.
    wait_idle();
    active = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      tick();
      gpio_in = 8'($urandom);
      if (rst) rst = 1'b0;
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1; active = 2'b00; bus.req_i = 2'b00;
      end else begin
        for (int r = 0; r < 2; r++) begin
          if (active[r] && exp_ack_f()[r]) begin
            active[r] = 1'b0; bus.req_i[r] = 1'b0;
          end else if (active[r] && m_cyc != 0 && m_who == r && $urandom_range(0, 5) == 0) begin
            bus.req_i[r] = 1'b0;
          end
          if (!active[r] && $urandom_range(0, 3) == 0) begin
            active[r] = 1'b1;
            bus.req_i[r] = 1'b1;
            bus.we_i[r] = 1'($urandom_range(0, 1));
            bus.addr_i[r] = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            bus.wdata_i[r] = 8'($urandom);
          end
        end
      end
    end
    rst = 1'b0; bus.req_i = 2'b00;
    wait_idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/as_gpio_ctrl.md
AS_GPIO_CTRL -- requirements
Module: as_gpio_ctrl

Interface
REQ-001 SHALL have parameter NR_GPIOS, default nr_gpios, meaning the external GPIO bus width.
REQ-002 SHALL have parameter ADDR_W, default gpio_addr_width, meaning the GPIO address width.
REQ-003 SHALL have parameter SETTLE_CYC, default 2, meaning the read settle cycles after cs_o (range 1..15).
REQ-004 SHALL have parameter GPIO_ID, default 8'h81, meaning the identification value returned for the ID address.
REQ-005 SHALL have port clk_i  in  1  system clock; the single clock domain.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port req_i  in  2  request per requester; [0]=core, [1]=debug/JTAG.
REQ-008 SHALL have port we_i  in  2  write enable per requester.
REQ-009 SHALL have port addr_i  in  2xADDR_W  address per requester.
REQ-010 SHALL have port wdata_i  in  2xNR_GPIOS  write data per requester.
REQ-011 SHALL have port ack_o  out  2  one-cycle completion pulse per requester.
REQ-012 SHALL have port rdata_o  out  NR_GPIOS  read data, valid in the ack cycle.
REQ-013 SHALL have port gpio_o  out  NR_GPIOS  pad output data.
REQ-014 SHALL have port gpio_oe_o  out  1  pad output enable; the tristate is resolved at top level.
REQ-015 SHALL have port gpio_i  in  NR_GPIOS  pad input data.
REQ-016 SHALL have port gpioAddr_o  out  ADDR_W  external address.
REQ-017 SHALL have port cs_o  out  1  external chip-select strobe.

Function
REQ-018 States SHALL be IDLE, SETUP, STROBE, SETTLE, SAMPLE, DONE.
REQ-019 In IDLE with any req_i high, the arbiter SHALL grant one requester, latch its we/addr/wdata, and go to SETUP on the next edge.
REQ-020 Arbitration SHALL be round-robin: when both requesters are requesting, the grant goes to the one not granted last; after reset, the core has priority.
REQ-021 A requester SHALL hold req_i and its operands stable until its ack; a drop before ack SHALL NOT abort the transaction.
REQ-022 SETUP (one cycle) SHALL drive gpioAddr_o, and for writes SHALL drive gpio_o=wdata and gpio_oe_o=1.
REQ-023 STROBE (one cycle) SHALL assert cs_o=1, with address, data and oe held unchanged.
REQ-024 Writes SHALL go STROBE->DONE; gpio_oe_o SHALL deassert on entry to DONE.
REQ-025 Reads SHALL go STROBE->SETTLE, with gpio_oe_o=0 throughout, wait SETTLE_CYC cycles, then go to SAMPLE.
REQ-026 SAMPLE SHALL register gpio_i into rdata_o.
REQ-027 DONE (one cycle) SHALL pulse ack_o for the granted requester only, then return to IDLE.
REQ-028 A read of address all-ones SHALL bypass the bus: IDLE->DONE with rdata_o=GPIO_ID zero-extended, and cs_o never asserted.
REQ-029 Latency, req accepted to ack: write = 4 cycles; read = 4+SETTLE_CYC cycles; ID read = 2 cycles.
REQ-030 A new grant SHALL NOT occur earlier than the cycle after DONE, so back-to-back transactions have at least one IDLE cycle.
REQ-031 cs_o SHALL be high in exactly one cycle per external transaction and SHALL never be high while gpio_oe_o is changing.
REQ-032 rdata_o SHALL hold its last value until the next SAMPLE or ID read; writes SHALL NOT alter it.

Reset
REQ-033 On rst_i=1 at a clock edge: state=IDLE; cs_o=0; gpio_oe_o=0; gpio_o=0; gpioAddr_o=0; ack_o=0; rdata_o=0; round-robin pointer=core.
REQ-034 A reset mid-transaction SHALL abort it with no ack, and the pads SHALL be released (oe=0) in the same edge.

Structure
REQ-035 The state enum, nr_gpios, gpio_addr_width and the ID-address constant SHALL live in as_pack.
REQ-036 The design SHALL have one sub-module, as_rr_arb2 (2-way round-robin arbiter with a last-grant register); the FSM and datapath SHALL be in as_gpio_ctrl.

Verification
REQ-037 Core write addr=3, data=8'h5A -> gpioAddr=3, oe=1 during SETUP/STROBE, a single cs_o pulse in cycle 3, ack_o[0] in cycle 4.
REQ-038 Debug read addr=2 with gpio_i=8'hC3, SETTLE_CYC=2 -> oe=0, cs_o once, rdata_o=8'hC3 with ack_o[1] at cycle 6.
REQ-039 Core read of addr all-ones -> rdata_o=8'h81 (129), ack_o[0] at cycle 2, cs_o stays 0.
REQ-040 Both requesters continuously requesting 4 writes each -> grants alternate core, debug, core, debug..., with no ack lost.
REQ-041 rst_i asserted during SETTLE -> next cycle state=IDLE, oe=0, no ack; a subsequent request completes normally.
